mpi_rx_classifier: RTL and testbench
====================================

// Module: mpi_rx_classifier
// PURPOSE
//  Receive-side MPI stage, directly downstream of the ethernet header stripper.
//  Consumes the 64-bit MPI stream whose first beat is the MPI header word.
//  Decodes the header and presents it on a sideband port to the rendezvous controller.
//  Forwards DATA-packet payload beats and drops the bodies of all control packets.
// PARAMETERS
//  RANK_CHECK  1   1: drop packets whose dst_rank != local_rank; 0: accept any rank
//  ERR_CNT_W   16  width of the saturating error counter
// PORTS
//  clk               in   1   single clock
//  aresetn           in   1   synchronous, active-low reset
//  local_rank        in   16  this node's rank; quasi-static
//  stream_in_data    in   64  MPI stream in
//  stream_in_keep    in   8   byte enables
//  stream_in_last    in   1   end of packet
//  stream_in_valid   in   1
//  stream_in_ready   out  1
//  payload_out_data  out  64  DATA payload out
//  payload_out_keep  out  8
//  payload_out_last  out  1
//  payload_out_valid out  1
//  payload_out_ready in   1
//  hdr_valid         out  1   decoded header available
//  hdr_ready         in   1
//  hdr_type          out  8   0 SYNC_ENV, 1 CLR2SND, 2 DATA, 3 ASYNC_ENV, 4 RECV_ERROR, 5 DONE
//  hdr_src           out  8
//  hdr_dst           out  16
//  hdr_size          out  16  bytes
//  hdr_tag           out  8
//  len_err           out  1   1-cycle pulse: DATA byte count != hdr_size at last beat
//  err_cnt           out  ERR_CNT_W  dropped packets plus length errors; saturates
// BEHAVIOUR
//  Header word layout: [63:56] version (must be 8'd1), [55:48] tag, [47:32] size,
//   [31:24] type, [23:16] src, [15:0] dst.
//  Reset (aresetn=0 at clk edge):
//   - all valid outputs, len_err and err_cnt go to 0; FSM goes to HDR.
//   - An in-flight packet is abandoned. Its remaining beats are parsed as new headers.
//  FSM states: HDR, PAYLOAD, DROP.
//   HDR:
//    - stream_in_ready = !hdr_valid.
//    - On accept, if version!=1, type>5, or (RANK_CHECK && dst!=local_rank):
//      no header is emitted, err_cnt+1, next state is DROP (or HDR if last=1).
//    - Otherwise the header registers load and hdr_valid=1 the next cycle.
//    - DATA with last=0 -> PAYLOAD, byte counter cleared.
//    - DATA with last=1 -> HDR; len_err pulses if size!=0.
//    - Any other type -> DROP if last=0, else HDR.
//   PAYLOAD:
//    - Beat moves to the payload output register; latency is 1 cycle.
//    - stream_in_ready = !payload_out_valid || payload_out_ready.
//    - Byte counter (16b, wraps) += popcount(keep).
//    - On the last beat: compare the final count to hdr_size, pulse len_err on
//      mismatch (err_cnt+1), go to HDR.
//   DROP:
//    - stream_in_ready = 1; beats are discarded; last -> HDR.
//  hdr_valid holds until hdr_ready; it is independent of payload flow.
//  A new header is not accepted while hdr_valid=1, so back-pressure reaches the input.
//  hdr_valid/hdr_ready and payload handshakes may complete in the same cycle.
//  A header is sampled, and payload flows, without waiting for hdr_ready.
//  err_cnt saturates at all-ones. Simultaneous drop and len_err in one cycle counts +1.
//  Outputs hold stable while valid && !ready (AXI-stream rules).
// STRUCTURE
//  Shared package mpi_pkg:
//   - packet-type localparams C_SYNC_ENV_PACKET..C_DATA_TRANSMISSION_DONE
//   - C_MPI_VERSION = 8'd1
//   - typedef struct packed mpi_hdr_t {ver, tag, size, ptype, src, dst} = 64b
//  Sub-module: mpi_hdr_decode (combinational unpack plus validity check).
//  FSM, byte counter, output register and error counter live in the top level.
// TESTING
//  1. SYNC_ENV header (src 3, dst 7 = local_rank) plus one zero beat with last=1
//     -> hdr type 0 / src 3 / dst 7; zero beat dropped; no payload_out beats.
//  2. DATA header, size 32, then 4 beats keep=FF, last on the 4th
//     -> 4 payload beats in order at 1-cycle latency, last on the 4th, len_err=0.
//  3. DATA header, size 30, 4 beats with last keep=3F -> no len_err.
//     Same packet with size 32 -> len_err pulse, err_cnt=1.
//  4. DATA header with dst 9 != local 7 (RANK_CHECK=1) plus 3 beats
//     -> no hdr_valid, no payload, err_cnt+1. Repeat with type 8 -> same.
//  5. hdr_ready=0 held while two CLR2SND single-beat packets arrive
//     -> stream_in_ready low after the first; second header delivered after hdr_ready.
//  6. aresetn=0 mid-PAYLOAD, random payload_out_ready
//     -> all valids 0, err_cnt 0; next beat is treated as a header.

Source files
------------

// File: rtl/mpi_pkg.sv
// Shared MPI definitions: packet types, protocol version, header layout,
// receive-FSM states and a byte-enable population count.
package mpi_pkg;

  localparam logic [7:0] C_SYNC_ENV_PACKET        = 8'd0;
  localparam logic [7:0] C_CLR2SND_PACKET         = 8'd1;
  localparam logic [7:0] C_DATA_PACKET            = 8'd2;
  localparam logic [7:0] C_ASYNC_ENV_PACKET       = 8'd3;
  localparam logic [7:0] C_RECV_ERROR_PACKET      = 8'd4;
  localparam logic [7:0] C_DATA_TRANSMISSION_DONE = 8'd5;

  localparam logic [7:0] C_MPI_VERSION = 8'd1;

  // First beat of every MPI packet, MSB first.
  typedef struct packed {
    logic [7:0]  ver;
    logic [7:0]  tag;
    logic [15:0] size;
    logic [7:0]  ptype;
    logic [7:0]  src;
    logic [15:0] dst;
  } mpi_hdr_t;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP
  } rx_state_t;

  // Number of valid bytes in one 64-bit beat.
  function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, keep[i]};
    return n;
  endfunction

endpackage

// File: rtl/mpi_hdr_decode.sv
// Combinational unpack of the MPI header word plus the accept/reject decision
// (version, known packet type, optional destination-rank match).
module mpi_hdr_decode
  import mpi_pkg::*;
#(
  parameter bit RANK_CHECK = 1'b1
) (
  input  logic [63:0] word,
  input  logic [15:0] local_rank,
  output logic [7:0]  tag,
  output logic [15:0] size,
  output logic [7:0]  ptype,
  output logic [7:0]  src,
  output logic [15:0] dst,
  output logic        hdr_ok
);

  mpi_hdr_t hdr;

  assign hdr   = mpi_hdr_t'(word);
  assign tag   = hdr.tag;
  assign size  = hdr.size;
  assign ptype = hdr.ptype;
  assign src   = hdr.src;
  assign dst   = hdr.dst;

  // Header is usable only with the right version, a known type and, when
  // enabled, a destination equal to this node's rank.
  always_comb begin
    hdr_ok = (hdr.ver == C_MPI_VERSION) &&
             (hdr.ptype <= C_DATA_TRANSMISSION_DONE) &&
             (!RANK_CHECK || (hdr.dst == local_rank));
  end

endmodule

// File: rtl/mpi_rx_classifier.sv
// Receive-side MPI classifier: decodes the header beat onto a sideband port,
// forwards DATA payload through a one-stage output register, discards control
// packet bodies and counts dropped packets and payload length errors.
module mpi_rx_classifier
  import mpi_pkg::*;
#(
  parameter bit RANK_CHECK = 1'b1,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [15:0]          local_rank,
  input  logic [63:0]          stream_in_data,
  input  logic [7:0]           stream_in_keep,
  input  logic                 stream_in_last,
  input  logic                 stream_in_valid,
  output logic                 stream_in_ready,
  output logic [63:0]          payload_out_data,
  output logic [7:0]           payload_out_keep,
  output logic                 payload_out_last,
  output logic                 payload_out_valid,
  input  logic                 payload_out_ready,
  output logic                 hdr_valid,
  input  logic                 hdr_ready,
  output logic [7:0]           hdr_type,
  output logic [7:0]           hdr_src,
  output logic [15:0]          hdr_dst,
  output logic [15:0]          hdr_size,
  output logic [7:0]           hdr_tag,
  output logic                 len_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  rx_state_t   state, state_next;
  logic        in_fire;
  logic        hdr_load, cnt_clear, pay_load, len_err_set, drop_set;
  logic [15:0] byte_cnt, byte_cnt_sum;

  logic [7:0]  dec_tag, dec_type, dec_src;
  logic [15:0] dec_size, dec_dst;
  logic        dec_ok;

  mpi_hdr_decode #(
    .RANK_CHECK(RANK_CHECK)
  ) u_decode (
    .word      (stream_in_data),
    .local_rank(local_rank),
    .tag       (dec_tag),
    .size      (dec_size),
    .ptype     (dec_type),
    .src       (dec_src),
    .dst       (dec_dst),
    .hdr_ok    (dec_ok)
  );

  assign in_fire      = stream_in_valid && stream_in_ready;
  assign byte_cnt_sum = byte_cnt + {12'b0, keep_bytes(stream_in_keep)};

  // Input back-pressure: a pending header blocks new headers, a stalled
  // payload register blocks payload beats, dropped bodies always flow.
  always_comb begin
    stream_in_ready = 1'b0;
    unique case (state)
      ST_HDR:     stream_in_ready = !hdr_valid;
      ST_PAYLOAD: stream_in_ready = !payload_out_valid || payload_out_ready;
      ST_DROP:    stream_in_ready = 1'b1;
      default:    stream_in_ready = 1'b0;
    endcase
  end

  // Next-state and per-beat control strobes.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves a value unassigned, which would infer a latch.
  always_comb begin
    state_next  = state;
    hdr_load    = 1'b0;
    cnt_clear   = 1'b0;
    pay_load    = 1'b0;
    len_err_set = 1'b0;
    drop_set    = 1'b0;
    unique case (state)
      ST_HDR: begin
        if (in_fire) begin
          if (!dec_ok) begin
            drop_set   = 1'b1;
            state_next = stream_in_last ? ST_HDR : ST_DROP;
          end else begin
            hdr_load = 1'b1;
            if (dec_type == C_DATA_PACKET) begin
              if (stream_in_last) begin
                // Header-only DATA packet: any nonzero size is a mismatch.
                len_err_set = (dec_size != 16'd0);
              end else begin
                cnt_clear  = 1'b1;
                state_next = ST_PAYLOAD;
              end
            end else begin
              state_next = stream_in_last ? ST_HDR : ST_DROP;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        if (in_fire) begin
          pay_load = 1'b1;
          if (stream_in_last) begin
            len_err_set = (byte_cnt_sum != hdr_size);
            state_next  = ST_HDR;
          end
        end
      end
      ST_DROP: begin
        if (in_fire && stream_in_last) state_next = ST_HDR;
      end
      default: state_next = ST_HDR;
    endcase
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!aresetn) state <= ST_HDR;
    else          state <= state_next;
  end

  // Header sideband valid: set on a decoded header, cleared on hdr_ready.
  always_ff @(posedge clk) begin
    if (!aresetn)      hdr_valid <= 1'b0;
    else if (hdr_load) hdr_valid <= 1'b1;
    else if (hdr_ready) hdr_valid <= 1'b0;
  end

  // Header field registers.
  // NOTE: pure datapath registers carry no reset; they are only observed
  // while their qualifying valid is high, and that valid is reset.
  always_ff @(posedge clk) begin
    if (hdr_load) begin
      hdr_type <= dec_type;
      hdr_src  <= dec_src;
      hdr_dst  <= dec_dst;
      hdr_size <= dec_size;
      hdr_tag  <= dec_tag;
    end
  end

  // Payload output valid: loaded by an accepted payload beat, drained by ready.
  always_ff @(posedge clk) begin
    if (!aresetn)               payload_out_valid <= 1'b0;
    else if (pay_load)          payload_out_valid <= 1'b1;
    else if (payload_out_ready) payload_out_valid <= 1'b0;
  end

  // Payload output data register; holds while stalled.
  always_ff @(posedge clk) begin
    if (pay_load) begin
      payload_out_data <= stream_in_data;
      payload_out_keep <= stream_in_keep;
      payload_out_last <= stream_in_last;
    end
  end

  // DATA byte counter, cleared at the header and wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (cnt_clear)     byte_cnt <= 16'd0;
    else if (pay_load) byte_cnt <= byte_cnt_sum;
  end

  // Length-error pulse and saturating error counter; a drop and a length
  // error in the same cycle count once.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      len_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      len_err <= len_err_set;
      if ((drop_set || len_err_set) && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mpi_rx_classifier.sv
// Directed scoreboard bench for mpi_rx_classifier. Expected headers and
// payload beats are queued as stimulus is driven and compared when the DUT
// hands them over. A narrow error counter makes saturation reachable.
module tb_mpi_rx_classifier;
  import mpi_pkg::*;

  localparam int ERR_W = 2;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [7:0]  ptype;
    logic [7:0]  src;
    logic [15:0] dst;
    logic [15:0] size;
    logic [7:0]  tag;
  } hdr_exp_t;

  logic             clk = 1'b0;
  logic             aresetn;
  logic [15:0]      local_rank;
  logic [63:0]      stream_in_data;
  logic [7:0]       stream_in_keep;
  logic             stream_in_last;
  logic             stream_in_valid;
  logic             stream_in_ready;
  logic [63:0]      payload_out_data;
  logic [7:0]       payload_out_keep;
  logic             payload_out_last;
  logic             payload_out_valid;
  logic             payload_out_ready;
  logic             hdr_valid;
  logic             hdr_ready;
  logic [7:0]       hdr_type;
  logic [7:0]       hdr_src;
  logic [15:0]      hdr_dst;
  logic [15:0]      hdr_size;
  logic [7:0]       hdr_tag;
  logic             len_err;
  logic [ERR_W-1:0] err_cnt;

  mpi_rx_classifier #(
    .RANK_CHECK(1'b1),
    .ERR_CNT_W (ERR_W)
  ) dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .local_rank       (local_rank),
    .stream_in_data   (stream_in_data),
    .stream_in_keep   (stream_in_keep),
    .stream_in_last   (stream_in_last),
    .stream_in_valid  (stream_in_valid),
    .stream_in_ready  (stream_in_ready),
    .payload_out_data (payload_out_data),
    .payload_out_keep (payload_out_keep),
    .payload_out_last (payload_out_last),
    .payload_out_valid(payload_out_valid),
    .payload_out_ready(payload_out_ready),
    .hdr_valid        (hdr_valid),
    .hdr_ready        (hdr_ready),
    .hdr_type         (hdr_type),
    .hdr_src          (hdr_src),
    .hdr_dst          (hdr_dst),
    .hdr_size         (hdr_size),
    .hdr_tag          (hdr_tag),
    .len_err          (len_err),
    .err_cnt          (err_cnt)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  beat_t      pay_q[$];
  hdr_exp_t   hdr_q[$];
  int         pay_seen = 0;
  int         hdr_seen = 0;
  int         len_err_seen = 0;
  logic [ERR_W-1:0] exp_err;
  beat_t      mon_b;
  hdr_exp_t   mon_h;
  logic       rand_ready = 1'b0;
  logic       pr_const   = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input logic [7:0] ver, input logic [7:0] tag,
                                         input logic [15:0] size, input logic [7:0] ptype,
                                         input logic [7:0] src, input logic [15:0] dst);
    return {ver, tag, size, ptype, src, dst};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + ERR_W'(1);
  endfunction

  // Payload-ready generator: constant or random, updated just after each edge.
  always @(posedge clk) begin
    #1;
    payload_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : pr_const;
  end

  // Output monitor: handshakes that will complete at the next edge are
  // compared against the scoreboard queues.
  always @(negedge clk) begin
    if (aresetn === 1'b1) begin
      if (len_err) len_err_seen++;
      if (payload_out_valid && payload_out_ready) begin
        pay_seen++;
        if (pay_q.size() == 0) check("pay_unexpected", 64'(payload_out_valid), 64'd0);
        else begin
          mon_b = pay_q.pop_front();
          check("pay_data", payload_out_data, mon_b.data);
          check("pay_keep", 64'(payload_out_keep), 64'(mon_b.keep));
          check("pay_last", 64'(payload_out_last), 64'(mon_b.last));
        end
      end
      if (hdr_valid && hdr_ready) begin
        hdr_seen++;
        if (hdr_q.size() == 0) check("hdr_unexpected", 64'(hdr_valid), 64'd0);
        else begin
          mon_h = hdr_q.pop_front();
          check("hdr_fields", 64'({hdr_type, hdr_src, hdr_dst, hdr_size, hdr_tag}), 64'(mon_h));
        end
      end
    end
  end

  // Waits for the current beat to be accepted; returns just after that edge.
  task automatic wait_accept(input string tag);
    logic r;
    int   n = 0;
    forever begin
      @(negedge clk);
      r = stream_in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 200) begin
        check({tag, "_accept_timeout"}, 64'(r), 64'd1);
        break;
      end
    end
  endtask

  task automatic drive(input logic [63:0] data, input logic [7:0] keep, input logic last);
    stream_in_data  = data;
    stream_in_keep  = keep;
    stream_in_last  = last;
    stream_in_valid = 1'b1;
  endtask

  task automatic send(input logic [63:0] data, input logic [7:0] keep, input logic last,
                      input string tag);
    drive(data, keep, last);
    wait_accept(tag);
  endtask

  task automatic send_hdr(input logic [7:0] ver, input logic [7:0] tag, input logic [15:0] size,
                          input logic [7:0] ptype, input logic [7:0] src, input logic [15:0] dst,
                          input logic last, input bit expect_hdr);
    if (expect_hdr) hdr_q.push_back('{ptype, src, dst, size, tag});
    send(mk_hdr(ver, tag, size, ptype, src, dst), 8'hFF, last, "hdr");
  endtask

  task automatic send_pay(input logic [63:0] data, input logic [7:0] keep, input logic last);
    pay_q.push_back('{data, keep, last});
    send(data, keep, last, "pay");
  endtask

  task automatic idle(input int n);
    stream_in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] keeps [4];
    aresetn         = 1'b0;
    local_rank      = 16'd7;
    stream_in_data  = '0;
    stream_in_keep  = '0;
    stream_in_last  = 1'b0;
    stream_in_valid = 1'b0;
    hdr_ready       = 1'b1;
    exp_err         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hdr_valid", 64'(hdr_valid), 64'd0);
    check("rst_pay_valid", 64'(payload_out_valid), 64'd0);
    check("rst_len_err", 64'(len_err), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    aresetn = 1'b1;
    idle(1);

    // 1: SYNC_ENV with one body beat that must be discarded.
    send_hdr(8'd1, 8'h11, 16'd0, C_SYNC_ENV_PACKET, 8'd3, 16'd7, 1'b0, 1'b1);
    send(64'd0, 8'hFF, 1'b1, "sync_body");
    idle(3);
    check("t1_hdr_seen", 64'(hdr_seen), 64'd1);
    check("t1_no_payload", 64'(pay_seen), 64'd0);

    // 2: DATA, 32 bytes in four full beats, one-cycle latency.
    send_hdr(8'd1, 8'h22, 16'd32, C_DATA_PACKET, 8'd4, 16'd7, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send_pay(64'h2000_0000_0000_0000 + 64'(i), 8'hFF, i == 3);
      if (i == 0) begin
        check("t2_latency_valid", 64'(payload_out_valid), 64'd1);
        check("t2_latency_data", payload_out_data, 64'h2000_0000_0000_0000);
      end
    end
    idle(3);
    check("t2_pay_seen", 64'(pay_seen), 64'd4);
    check("t2_no_len_err", 64'(len_err_seen), 64'd0);

    // 3: partial last beat matching size 30, then same beats against size 32.
    keeps = '{8'hFF, 8'hFF, 8'hFF, 8'h3F};
    send_hdr(8'd1, 8'h33, 16'd30, C_DATA_PACKET, 8'd4, 16'd7, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_pay(64'h3000_0000_0000_0000 + 64'(i), keeps[i], i == 3);
    idle(3);
    check("t3_size30_len_err", 64'(len_err_seen), 64'd0);
    send_hdr(8'd1, 8'h34, 16'd32, C_DATA_PACKET, 8'd4, 16'd7, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_pay(64'h3400_0000_0000_0000 + 64'(i), keeps[i], i == 3);
    idle(3);
    exp_err = sat_inc(exp_err);
    check("t3_size32_len_err", 64'(len_err_seen), 64'd1);
    check("t3_err_cnt", 64'(err_cnt), 64'(exp_err));

    // 4: wrong rank, bad type, bad version (error counter saturates).
    send_hdr(8'd1, 8'h44, 16'd24, C_DATA_PACKET, 8'd4, 16'd9, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(64'h4400 + 64'(i), 8'hFF, i == 2, "drop_rank");
    idle(2);
    exp_err = sat_inc(exp_err);
    check("t4_rank_hdr_valid", 64'(hdr_valid), 64'd0);
    check("t4_rank_err_cnt", 64'(err_cnt), 64'(exp_err));
    send_hdr(8'd1, 8'h45, 16'd24, 8'd8, 8'd4, 16'd7, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(64'h4500 + 64'(i), 8'hFF, i == 2, "drop_type");
    idle(2);
    exp_err = sat_inc(exp_err);
    check("t4_type_err_cnt", 64'(err_cnt), 64'(exp_err));
    send_hdr(8'd2, 8'h46, 16'd0, C_SYNC_ENV_PACKET, 8'd4, 16'd7, 1'b1, 1'b0);
    idle(2);
    exp_err = sat_inc(exp_err);
    check("t4_sat_err_cnt", 64'(err_cnt), 64'(exp_err));
    check("t4_pay_seen", 64'(pay_seen), 64'd12);

    // 5: header back-pressure with two single-beat CLR2SND packets.
    hdr_ready = 1'b0;
    send_hdr(8'd1, 8'h55, 16'd0, C_CLR2SND_PACKET, 8'd1, 16'd7, 1'b1, 1'b1);
    hdr_q.push_back('{C_CLR2SND_PACKET, 8'd2, 16'd7, 16'd0, 8'h56});
    drive(mk_hdr(8'd1, 8'h56, 16'd0, C_CLR2SND_PACKET, 8'd2, 16'd7), 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_in_ready_low", 64'(stream_in_ready), 64'd0);
    end
    check("t5_hdr_held_tag", 64'({hdr_valid, hdr_tag}), 64'h155);
    @(posedge clk);
    #1;
    hdr_ready = 1'b1;
    wait_accept("t5_second");
    idle(3);
    check("t5_hdr_seen", 64'(hdr_seen), 64'd6);

    // 6: reset in the middle of a payload with random output back-pressure.
    rand_ready = 1'b1;
    send_hdr(8'd1, 8'h66, 16'd64, C_DATA_PACKET, 8'd4, 16'd7, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send_pay(64'h6600 + 64'(i), 8'hFF, 1'b0);
    stream_in_valid = 1'b0;
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    pay_q.delete();
    exp_err = '0;
    check("t6_rst_pay_valid", 64'(payload_out_valid), 64'd0);
    check("t6_rst_hdr_valid", 64'(hdr_valid), 64'd0);
    check("t6_rst_err_cnt", 64'(err_cnt), 64'd0);
    aresetn = 1'b1;
    // Leftover body beats are now parsed as headers.
    send(64'hDEAD_BEEF_0000_0000, 8'hFF, 1'b1, "t6_garbage");
    send_hdr(8'd1, 8'h67, 16'd0, C_CLR2SND_PACKET, 8'd5, 16'd7, 1'b0, 1'b1);
    send(64'h6700, 8'hFF, 1'b1, "t6_body");
    idle(3);
    exp_err = sat_inc(exp_err);
    check("t6_garbage_err_cnt", 64'(err_cnt), 64'(exp_err));
    rand_ready = 1'b0;
    // Header-only DATA packet with nonzero size.
    send_hdr(8'd1, 8'h68, 16'd8, C_DATA_PACKET, 8'd5, 16'd7, 1'b1, 1'b1);
    idle(3);
    exp_err = sat_inc(exp_err);
    check("t6_hdr_only_len_err", 64'(len_err_seen), 64'd2);
    check("t6_hdr_only_err_cnt", 64'(err_cnt), 64'(exp_err));

    idle(5);
    check("end_pay_q_empty", 64'(pay_q.size()), 64'd0);
    check("end_hdr_q_empty", 64'(hdr_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
